// File: rtl/tuple_array_pkg.sv
// Shared types and helpers for the Array(N, Tuple(Bit, Bits(W1))) shuffle/unshuffle stages.
// rev_idx is the field-0 index reversal used on both sides of the link.
package tuple_array_pkg;

  localparam int N_DEF  = 4;
  localparam int W1_DEF = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  typedef struct packed {
    logic              f0;
    logic [W1_DEF-1:0] f1;
  } elem_t;

  function automatic int rev_idx(input int i, input int n = N_DEF);
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/array2_beat_counter.sv
// Beat index within the array being collected; load1 wins over clear, clear over inc.
// is_last flags the final element slot (idx == N-1).
module array2_beat_counter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          ASYNCRESETN,
  input  logic          inc,
  input  logic          clear,
  input  logic          load1,
  output logic [IW-1:0] idx,
  output logic          is_last
);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      idx <= '0;
    end else if (load1) begin
      idx <= IW'(1);
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + IW'(1);
    end
  end

  assign is_last = (idx == IW'(N - 1));

endmodule

// File: rtl/array2_tuple_deserializer.sv
// Collects N shuffled tuple beats, restores field-0 order and presents the array as one word.
// One cycle from the last beat to O_valid; while holding, I_ready tracks O_ready so a take and a new beat can overlap.
module array2_tuple_deserializer
  import tuple_array_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W1 = W1_DEF
) (
  input  logic            CLK,
  input  logic            ASYNCRESETN,
  input  logic            I_valid,
  output logic            I_ready,
  input  logic            I__0,
  input  logic [W1-1:0]   I__1,
  input  logic            I_last,
  output logic            O_valid,
  input  logic            O_ready,
  output logic [N-1:0]    O__0,
  output logic [N*W1-1:0] O__1,
  output logic            err,
  input  logic            err_clr
);

  localparam int IW = $clog2(N);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            is_last;
  logic [N-1:0]    col_f0;
  logic [N-1:0]    col_f0_nxt;
  logic [N*W1-1:0] col_f1;
  logic [N*W1-1:0] col_f1_nxt;
  logic            in_collect;
  logic            accept;
  logic            take;
  logic            done;
  logic            frame_err;
  logic            cnt_inc;
  logic            cnt_clear;
  logic            cnt_load1;

  // I_ready depends only on state and O_ready, never on I_valid.
  assign in_collect = (state == COLLECT);
  assign I_ready    = in_collect | O_ready;
  assign accept     = I_valid & I_ready;
  assign take       = O_valid & O_ready;

  assign done       = in_collect & accept & is_last & I_last;
  assign frame_err  = in_collect & accept & (I_last ^ is_last);
  assign cnt_inc    = in_collect & accept & ~I_last & ~is_last;
  assign cnt_clear  = done | frame_err | (~in_collect & take & ~accept);
  // In HOLD an accepted beat always coincides with a take and becomes element 0.
  assign cnt_load1  = ~in_collect & accept;

  array2_beat_counter #(
    .N  (N),
    .IW (IW)
  ) u_beat_counter (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .inc         (cnt_inc),
    .clear       (cnt_clear),
    .load1       (cnt_load1),
    .idx         (idx),
    .is_last     (is_last)
  );

  // Collect regs with the current beat merged in; also the source for the output load.
  always_comb begin
    col_f0_nxt = col_f0;
    col_f1_nxt = col_f1;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        col_f0_nxt[rev_idx(i, N)] = I__0;
        col_f1_nxt[i*W1 +: W1]    = I__1;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= COLLECT;
      O_valid <= 1'b0;
      O__0    <= '0;
      O__1    <= '0;
      col_f0  <= '0;
      col_f1  <= '0;
      err     <= 1'b0;
    end else begin
      if (frame_err) begin
        col_f0 <= '0;
        col_f1 <= '0;
      end else if (accept) begin
        col_f0 <= col_f0_nxt;
        col_f1 <= col_f1_nxt;
      end

      if (frame_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        COLLECT: begin
          if (done) begin
            state   <= HOLD;
            O_valid <= 1'b1;
            O__0    <= col_f0_nxt;
            O__1    <= col_f1_nxt;
          end
        end
        HOLD: begin
          if (take) begin
            state   <= COLLECT;
            O_valid <= 1'b0;
          end
        end
        default: begin
          state   <= COLLECT;
          O_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array2_tuple_deserializer.sv
// Scoreboard bench for array2_tuple_deserializer: an inverse-shuffle model predicts arrays, flags and handshakes.
module tb_array2_tuple_deserializer;
  import tuple_array_pkg::*;

  localparam int N  = 4;
  localparam int W1 = 2;

  logic            CLK = 1'b0;
  logic            ASYNCRESETN = 1'b1;
  logic            I_valid = 1'b0;
  logic            I__0 = 1'b0;
  logic [W1-1:0]   I__1 = '0;
  logic            I_last = 1'b0;
  logic            O_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            I_ready;
  logic            O_valid;
  logic            err;
  logic [N-1:0]    O__0;
  logic [N*W1-1:0] O__1;

  typedef struct packed {
    logic [N-1:0]    f0;
    logic [N*W1-1:0] f1;
  } arr_t;

  int     vectors = 0;
  int     miscompares = 0;
  arr_t   exp_q[$];
  elem_t  mb[N];
  logic   m_hold = 1'b0;
  logic   m_err = 1'b0;
  int     m_idx = 0;
  int     cyc = 0;
  logic   took = 1'b0;

  array2_tuple_deserializer #(.N(N), .W1(W1)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .I__0        (I__0),
    .I__1        (I__1),
    .I_last      (I_last),
    .O_valid     (O_valid),
    .O_ready     (O_ready),
    .O__0        (O__0),
    .O__1        (O__1),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called a few ns before each rising edge: compare, then advance the model past that edge.
  task automatic sample();
    logic acc;
    logic new_err;
    arr_t e;
    acc  = I_valid && (m_hold ? O_ready : 1'b1);
    took = m_hold && O_ready;
    check("o_valid", {63'd0, O_valid}, {63'd0, m_hold});
    check("err", {63'd0, err}, {63'd0, m_err});
    check("i_ready", {63'd0, I_ready}, {63'd0, (m_hold ? O_ready : 1'b1)});
    if (m_hold) begin
      if (exp_q.size() == 0) begin
        check("q_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        check("o_f0", 64'(O__0), 64'(exp_q[0].f0));
        check("o_f1", 64'(O__1), 64'(exp_q[0].f1));
        if (O_ready) void'(exp_q.pop_front());
      end
    end
    new_err = 1'b0;
    if (m_hold) begin
      if (O_ready) begin
        m_hold = 1'b0;
        m_idx  = 0;
        if (acc) begin
          mb[0] = '{f0: I__0, f1: I__1};
          m_idx = 1;
        end
      end
    end else if (acc) begin
      mb[m_idx] = '{f0: I__0, f1: I__1};
      if (m_idx == N-1 && I_last) begin
        for (int i = 0; i < N; i++) begin
          e.f0[i]           = mb[N-1-i].f0;
          e.f1[i*W1 +: W1]  = mb[i].f1;
        end
        exp_q.push_back(e);
        m_hold = 1'b1;
        m_idx  = 0;
      end else if (I_last || m_idx == N-1) begin
        new_err = 1'b1;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end
    if (new_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic tick(input logic v, input logic f0, input logic [W1-1:0] f1,
                      input logic last, input logic ordy, input logic clr);
    @(negedge CLK);
    I_valid = v;
    I__0    = f0;
    I__1    = f1;
    I_last  = last;
    O_ready = ordy;
    err_clr = clr;
    cyc++;
    #3;
    sample();
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 1'b0, 2'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    int prev;
    int ntake;
    logic last;
    logic v;

    #1 ASYNCRESETN = 1'b0;
    #1;
    check("rst_o_valid", {63'd0, O_valid}, 64'd0);
    check("rst_o_f0", 64'(O__0), 64'd0);
    check("rst_o_f1", 64'(O__1), 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_i_ready", {63'd0, I_ready}, 64'd1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Basic array, O_valid the cycle after the last beat
    tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    check("t1_o_f0", 64'(O__0), 64'(4'b1001));
    check("t1_o_f1", 64'(O__1), 64'(8'b11_10_01_00));
    idle(1'b1);

    // Output stall: held data, no input acceptance, then take + accept overlap
    tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      check("t2_stall_f0", 64'(O__0), 64'(4'b1000));
      check("t2_stall_f1", 64'(O__1), 64'(8'b01_00_00_11));
      check("t2_stall_rdy", {63'd0, I_ready}, 64'd0);
    end
    tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Back-to-back arrays: one take every N cycles
    prev  = -1;
    ntake = 0;
    for (int k = 0; k < 16; k++) begin
      last = !m_hold && (m_idx == N-1);
      tick(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), last, 1'b1, 1'b0);
      if (took) begin
        ntake++;
        if (prev >= 0) check("t3_period", 64'(cyc - prev), 64'(N));
        prev = cyc;
      end
    end
    check("t3_takes", 64'(ntake), 64'd3);
    idle(1'b1);

    // Early last: error, no array; following clean array intact; err_clr
    tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("t4_err_set", {63'd0, err}, 64'd1);
    tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    check("t4_o_f0", 64'(O__0), 64'(4'b0110));
    check("t4_o_f1", 64'(O__1), 64'(8'b01_01_11_10));
    idle(1'b1);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("t4_err_clr", {63'd0, err}, 64'd0);

    // Asynchronous reset mid-collection
    tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    #4;
    I_valid     = 1'b0;
    ASYNCRESETN = 1'b0;
    #1;
    check("t5_o_valid", {63'd0, O_valid}, 64'd0);
    check("t5_o_f0", 64'(O__0), 64'd0);
    check("t5_o_f1", 64'(O__1), 64'd0);
    check("t5_i_ready", {63'd0, I_ready}, 64'd1);
    m_hold = 1'b0;
    m_idx  = 0;
    m_err  = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Random valid/ready gaps, occasional framing errors and clears
    ntake = 0;
    for (int c = 0; c < 60000 && ntake < 1000; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      last = !m_hold && (m_idx == N-1);
      if (!m_hold && $urandom_range(0, 99) == 0) last = ~last;
      tick(v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), last,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      if (took) ntake++;
    end
    check("t6_arrays", 64'(ntake), 64'd1000);
    check("t6_q_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
